// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : phase encodings, default 640x480@60 timing and counter widths
// Revision: 1.0
// ============================================================================
package vga_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_SYNC = 3'd1,
    PH_BP   = 3'd2,
    PH_DISP = 3'd3,
    PH_FP   = 3'd4
  } phase_e;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 10;
  localparam int VPIX_W  = 7;
  localparam int REP_W   = 3;

  localparam int c_H_SYNC = 384;
  localparam int c_H_BP   = 192;
  localparam int c_H_DISP = 2560;
  localparam int c_H_FP   = 64;
  localparam int c_V_SYNC = 2;
  localparam int c_V_BP   = 33;
  localparam int c_V_DISP = 480;
  localparam int c_V_FP   = 10;
  localparam int c_V_REP  = 5;

endpackage
`default_nettype wire

// File: rtl/vga_phase_seq.sv
`default_nettype none
// ============================================================================
// vga_phase_seq : SYNC/BP/DISP/FP phase FSM with an in-phase counter that
//                 steps on i_advance. Revision: 1.0
// ============================================================================
module vga_phase_seq
  import vga_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int SYNC_LEN = 384,
  parameter int BP_LEN   = 192,
  parameter int DISP_LEN = 2560,
  parameter int FP_LEN   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_advance,
  output phase_e           o_phase,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_phase_end
);

  localparam logic [CNT_W-1:0] c_SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] c_BP_LAST   = CNT_W'(BP_LEN - 1);
  localparam logic [CNT_W-1:0] c_DISP_LAST = CNT_W'(DISP_LEN - 1);
  localparam logic [CNT_W-1:0] c_FP_LAST   = CNT_W'(FP_LEN - 1);

  phase_e           r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_last;
  logic             w_phase_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_last = '0;
    case (r_phase)
      PH_SYNC: w_last = c_SYNC_LAST;
      PH_BP:   w_last = c_BP_LAST;
      PH_DISP: w_last = c_DISP_LAST;
      PH_FP:   w_last = c_FP_LAST;
      default: w_last = '0;
    endcase
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_phase_end = 1'b0;
    if (!i_en) begin
      w_phase_nxt = PH_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_phase == PH_IDLE) begin
      // Leaving IDLE always starts a fresh period at the sync pulse.
      w_phase_nxt = PH_SYNC;
      w_cnt_nxt   = '0;
    end else if (i_advance) begin
      if (r_cnt == w_last) begin
        w_phase_end = 1'b1;
        w_cnt_nxt   = '0;
        case (r_phase)
          PH_SYNC: w_phase_nxt = PH_BP;
          PH_BP:   w_phase_nxt = PH_DISP;
          PH_DISP: w_phase_nxt = PH_FP;
          PH_FP:   w_phase_nxt = PH_SYNC;
          default: w_phase_nxt = PH_IDLE;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_phase     = r_phase;
  assign o_cnt       = r_cnt;
  assign o_phase_end = w_phase_end;

endmodule
`default_nettype wire

// File: rtl/vga_sync_controller.sv
`default_nettype none
// ============================================================================
// vga_sync_controller : 640x480@60 sync generator, pixel enable and VRAM row
//                       address for a 128x96 frame scaled 5x. Revision: 1.0
// ============================================================================
module vga_sync_controller
  import vga_pkg::*;
#(
  parameter int H_SYNC = c_H_SYNC,
  parameter int H_BP   = c_H_BP,
  parameter int H_DISP = c_H_DISP,
  parameter int H_FP   = c_H_FP,
  parameter int V_SYNC = c_V_SYNC,
  parameter int V_BP   = c_V_BP,
  parameter int V_DISP = c_V_DISP,
  parameter int V_FP   = c_V_FP,
  parameter int V_REP  = c_V_REP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              hpixel_en,
  output logic [VPIX_W-1:0] vpixel,
  output logic              frame_start
);

  phase_e               w_h_phase, w_v_phase;
  logic [H_CNT_W-1:0]   w_hcnt;
  logic [V_CNT_W-1:0]   w_vcnt;
  logic                 w_h_end, w_v_end, w_line_end;
  logic [VPIX_W-1:0]    r_vpixel;
  logic [REP_W-1:0]     r_rep;

  vga_phase_seq #(
    .CNT_W(H_CNT_W), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .DISP_LEN(H_DISP), .FP_LEN(H_FP)
  ) u_hseq (
    .clk(clk), .reset(reset), .i_en(en), .i_advance(1'b1),
    .o_phase(w_h_phase), .o_cnt(w_hcnt), .o_phase_end(w_h_end)
  );

  assign w_line_end = w_h_end && (w_h_phase == PH_FP);

  vga_phase_seq #(
    .CNT_W(V_CNT_W), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .DISP_LEN(V_DISP), .FP_LEN(V_FP)
  ) u_vseq (
    .clk(clk), .reset(reset), .i_en(en), .i_advance(w_line_end),
    .o_phase(w_v_phase), .o_cnt(w_vcnt), .o_phase_end(w_v_end)
  );

  // Clearing on the last visible line's end keeps vpixel from ever reaching 96.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vpixel <= '0;
      r_rep    <= '0;
    end else if (!en || (w_v_phase != PH_DISP) || w_v_end) begin
      r_vpixel <= '0;
      r_rep    <= '0;
    end else if (w_line_end) begin
      if (r_rep == REP_W'(V_REP - 1)) begin
        r_rep    <= '0;
        r_vpixel <= r_vpixel + VPIX_W'(1);
      end else begin
        r_rep <= r_rep + REP_W'(1);
      end
    end
  end

  assign hsync_n     = (w_h_phase != PH_SYNC);
  assign vsync_n     = (w_v_phase != PH_SYNC);
  assign hpixel_en   = (w_h_phase == PH_DISP) && (w_v_phase == PH_DISP);
  assign vpixel      = r_vpixel;
  assign frame_start = (w_h_phase == PH_SYNC) && (w_v_phase == PH_SYNC) &&
                       (w_hcnt == '0) && (w_vcnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_controller.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_controller : full-size horizontal timing on one instance, a
//                          compact-timing instance for whole-frame checks.
// ============================================================================
module tb_vga_sync_controller;

  localparam int LB    = 54;          // 6+4+40+4 clk per line, compact instance
  localparam int FRAME = 199 * LB;    // 2+3+192+2 lines

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b1, rst_b = 1'b1, en_b = 1'b1;
  logic hs_a, vs_a, hp_a, fs_a, hs_b, vs_b, hp_b, fs_b;
  logic [6:0] vp_a, vp_b;

  vga_sync_controller u_dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .hsync_n(hs_a), .vsync_n(vs_a),
    .hpixel_en(hp_a), .vpixel(vp_a), .frame_start(fs_a)
  );

  vga_sync_controller #(
    .H_SYNC(6), .H_BP(4), .H_DISP(40), .H_FP(4),
    .V_SYNC(2), .V_BP(3), .V_DISP(192), .V_FP(2), .V_REP(2)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .hsync_n(hs_b), .vsync_n(vs_b),
    .hpixel_en(hp_b), .vpixel(vp_b), .frame_start(fs_b)
  );

  int total = 0, bad = 0;
  int t = -1;
  bit count_on = 1'b0;
  int cnt_hs = 0, cnt_vs = 0, cnt_hp = 0, cnt_fs = 0, first_hp = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick_b();
    @(posedge clk); #1;
    t++;
    if (count_on && t >= 0 && t < FRAME) begin
      cnt_hs += int'(!hs_b);
      cnt_vs += int'(!vs_b);
      cnt_hp += int'(hp_b);
      cnt_fs += int'(fs_b);
      if (hp_b && first_hp < 0) first_hp = t;
    end
  endtask

  task automatic chk_idle_b(input string tag);
    chk({tag, ".hsync_n"}, 32'(hs_b), 32'd1);
    chk({tag, ".vsync_n"}, 32'(vs_b), 32'd1);
    chk({tag, ".hpixel_en"}, 32'(hp_b), 32'd0);
    chk({tag, ".vpixel"}, 32'(vp_b), 32'd0);
    chk({tag, ".frame_start"}, 32'(fs_b), 32'd0);
  endtask

  typedef struct {
    int   line;
    int   cyc;
    logic hs;
    logic vs;
    logic hp;
    logic fs;
    int   vp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int line, input int cyc, input logic hs,
                              input logic vs, input logic hp, input logic fs, input int vp);
    vec_t v;
    v.line = line; v.cyc = cyc; v.hs = hs; v.vs = vs; v.hp = hp; v.fs = fs; v.vp = vp;
    return v;
  endfunction

  initial begin
    int a_hs, a_vs, a_hp;
    a_hs = 0; a_vs = 0; a_hp = 0;

    //        line cyc  hs   vs   hp   fs   vp
    tbl.push_back(mk(  0,  0, 1'b0, 1'b0, 1'b0, 1'b1,  0));
    tbl.push_back(mk(  0,  5, 1'b0, 1'b0, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  0,  6, 1'b1, 1'b0, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  1,  0, 1'b0, 1'b0, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  2,  0, 1'b0, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  4, 53, 1'b1, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  5,  9, 1'b1, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  5, 10, 1'b1, 1'b1, 1'b1, 1'b0,  0));
    tbl.push_back(mk(  5, 49, 1'b1, 1'b1, 1'b1, 1'b0,  0));
    tbl.push_back(mk(  5, 50, 1'b1, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(  6, 10, 1'b1, 1'b1, 1'b1, 1'b0,  0));
    tbl.push_back(mk(  7,  0, 1'b0, 1'b1, 1'b0, 1'b0,  1));
    tbl.push_back(mk(  7, 10, 1'b1, 1'b1, 1'b1, 1'b0,  1));
    tbl.push_back(mk(196, 10, 1'b1, 1'b1, 1'b1, 1'b0, 95));
    tbl.push_back(mk(196, 53, 1'b1, 1'b1, 1'b0, 1'b0, 95));
    tbl.push_back(mk(197,  0, 1'b0, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(198, 53, 1'b1, 1'b1, 1'b0, 1'b0,  0));
    tbl.push_back(mk(199,  0, 1'b0, 1'b0, 1'b0, 1'b1,  0));

    // Reset held with en high: every output at its idle value.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.hsync_n", 32'(hs_a), 32'd1);
    chk("rst.vsync_n", 32'(vs_a), 32'd1);
    chk("rst.hpixel_en", 32'(hp_a), 32'd0);
    chk("rst.vpixel", 32'(vp_a), 32'd0);
    chk("rst.frame_start", 32'(fs_a), 32'd0);

    // Full-size timing: first lines of a frame.
    rst_a = 1'b0;
    for (int s = 0; s <= 9600; s++) begin
      @(posedge clk); #1;
      if (s == 0) begin
        chk("a.first_fs", 32'(fs_a), 32'd1);
        chk("a.first_hs", 32'(hs_a), 32'd0);
      end
      if (s == 1) chk("a.fs_one_cycle", 32'(fs_a), 32'd0);
      if (s == 3199) chk("a.hs_before_period", 32'(hs_a), 32'd1);
      if (s == 3200) begin
        chk("a.hs_period_3200", 32'(hs_a), 32'd0);
        chk("a.fs_line1", 32'(fs_a), 32'd0);
      end
      if (s == 6400) chk("a.vs_after_2_lines", 32'(vs_a), 32'd1);
      if (s < 3200) a_hs += int'(!hs_a);
      if (s < 6400) a_vs += int'(!vs_a);
      a_hp += int'(hp_a);
    end
    chk("a.hs_low_cycles", 32'(a_hs), 32'd384);
    chk("a.vs_low_cycles", 32'(a_vs), 32'd6400);
    chk("a.hp_in_sync_bp", 32'(a_hp), 32'd0);
    rst_a = 1'b1;

    // Compact instance: one whole frame against the table.
    chk_idle_b("b.rst");
    rst_b    = 1'b0;
    count_on = 1'b1;
    foreach (tbl[i]) begin
      while (t < tbl[i].line * LB + tbl[i].cyc) tick_b();
      chk($sformatf("tbl%0d.hsync_n", i), 32'(hs_b), 32'(tbl[i].hs));
      chk($sformatf("tbl%0d.vsync_n", i), 32'(vs_b), 32'(tbl[i].vs));
      chk($sformatf("tbl%0d.hpixel_en", i), 32'(hp_b), 32'(tbl[i].hp));
      chk($sformatf("tbl%0d.frame_start", i), 32'(fs_b), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d.vpixel", i), 32'(vp_b), 32'(tbl[i].vp));
    end
    count_on = 1'b0;
    chk("b.frame_hs_low", 32'(cnt_hs), 32'(199 * 6));
    chk("b.frame_vs_low", 32'(cnt_vs), 32'(2 * LB));
    chk("b.frame_hp_high", 32'(cnt_hp), 32'(192 * 40));
    chk("b.frame_fs_count", 32'(cnt_fs), 32'd1);
    chk("b.first_hp", 32'(first_hp), 32'(5 * LB + 10));

    // en dropped mid visible line of the second frame.
    while (t < FRAME + 100 * LB + 20) tick_b();
    chk("en.hp_before", 32'(hp_b), 32'd1);
    chk("en.vp_before", 32'(vp_b), 32'd47);
    en_b = 1'b0;
    tick_b();
    chk_idle_b("en.off");
    repeat (3) tick_b();
    chk_idle_b("en.off_hold");
    en_b = 1'b1;
    tick_b();
    chk("en.restart_fs", 32'(fs_b), 32'd1);
    chk("en.restart_hs", 32'(hs_b), 32'd0);
    chk("en.restart_vs", 32'(vs_b), 32'd0);
    t = 0;
    tick_b();
    chk("en.fs_one_cycle", 32'(fs_b), 32'd0);

    // Asynchronous reset while vpixel = 40.
    while (t < 85 * LB + 20) tick_b();
    chk("rstmid.vp_before", 32'(vp_b), 32'd40);
    #2 rst_b = 1'b1;
    #1 chk_idle_b("rstmid.async");
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    t = -1;
    tick_b();
    chk("rstmid.restart_fs", 32'(fs_b), 32'd1);
    chk("rstmid.restart_hs", 32'(hs_b), 32'd0);
    while (t < 5 * LB + 9) tick_b();
    chk("rstmid.hp_pre", 32'(hp_b), 32'd0);
    tick_b();
    chk("rstmid.hp_first", 32'(hp_b), 32'd1);
    chk("rstmid.vp_first", 32'(vp_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
